// File: rtl/uart_verici.sv
// uart_verici: TX FIFO feeding an 8N1 serialiser with a programmable bit period
module uart_verici #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             we_i,
    input  logic             stall_i,
    input  logic [7:0]       data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             busy_o,
    output logic             tx_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, empty_q;
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, bcnt_q, bcnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             push, pop, launch, bit_end;

    assign push    = we_i & ~full_q;
    assign launch  = ~stall_i & ~empty_q & (baud_div_i != '0);
    assign bit_end = bcnt_q == div_q - DIV_W'(1);
    assign pop     = launch & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

    // FIFO pointer and occupancy next state; pointers wrap naturally (power-of-two depth)
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    // FIFO storage needs no reset: entries are only read when the count says they are valid
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    // FIFO pointers, count and flags registered from the next count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= cnt_d == CW'(FIFO_DEPTH);
            empty_q  <= cnt_d == '0;
        end
    end

    // Frame sequencer; tx is derived from the next state so the line comes straight off a flop
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q + DIV_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        div_d   = div_q;
        case (state_q)
            IDLE: bcnt_d = '0;
            START: begin
                if (bit_end) begin
                    bcnt_d  = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bcnt_d  = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    state_d = (idx_q == 3'd7) ? STOP : DATA;
                end
            end
            default: begin
                if (bit_end) begin
                    bcnt_d  = '0;
                    state_d = IDLE;
                end
            end
        endcase
        if (pop) begin
            bcnt_d  = '0;
            shift_d = mem_q[rd_ptr_q];
            div_d   = baud_div_i;
            state_d = START;
        end
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end

    // Frame sequencer registers; reset forces the line idle high at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            div_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign busy_o  = state_q != IDLE;
    assign tx_o    = tx_q;
endmodule

// File: tb/tb_uart_verici.sv
// tb_uart_verici: directed + random stimulus against a frame-level reference model
module tb_uart_verici;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [15:0] div = 16'd0;
    logic        full, empty, busy, tx;

    int vectors = 0;
    int miscompares = 0;

    // reference model: byte queue plus the frame in flight (byte, period, cycles since launch)
    logic [7:0] q[$];
    bit         act = 1'b0;
    int         t = 0;
    int         d = 0;
    logic [7:0] cur = 8'h00;

    uart_verici #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .baud_div_i(div), .we_i(we), .stall_i(stall),
        .data_i(data), .full_o(full), .empty_o(empty), .busy_o(busy), .tx_o(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic obs, logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int b;
        if (!act) return 1'b1;
        b = t / d;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        act = 1'b0;
        t = 0;
    endtask

    // one clock edge of the reference: frame of 10*d cycles, then launch if allowed
    task automatic model_edge();
        bit full_m, empty_m, l;
        if (rst) begin
            model_reset();
            return;
        end
        full_m  = q.size() == DEPTH;
        empty_m = q.size() == 0;
        l = !stall && !empty_m && div != 16'd0;
        if (act) begin
            t++;
            if (t == 10 * d) act = 1'b0;
        end
        if (!act && l) begin
            cur = q.pop_front();
            d = int'(div);
            t = 0;
            act = 1'b1;
        end
        if (we && !full_m) q.push_back(data);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("tx", tx, exp_tx());
        chk("busy", busy, act);
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_step(logic [7:0] b);
        we = 1'b1;
        data = b;
        step();
        we = 1'b0;
    endtask

    // asynchronous reset pulse between edges, checked before the next edge arrives
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // reset state
        run(2);
        rst = 1'b0;
        run(2);
        // single 0x55 frame at 4 clocks per bit
        div = 16'd4;
        push_step(8'h55);
        run(45);
        // fill while stalled, overflow dropped, then back-to-back drain
        stall = 1'b1;
        div = 16'($urandom_range(1, 3));
        for (int i = 1; i <= 9; i++) push_step(8'(i));
        run(3);
        stall = 1'b0;
        run(80 * int'(div) + 5);
        // stall raised during data bit 3 holds back the second byte
        div = 16'd2;
        push_step(8'hA3);
        push_step(8'($urandom));
        run(7);
        stall = 1'b1;
        run(30);
        stall = 1'b0;
        run(25);
        // zero divisor holds the transmitter idle
        div = 16'd0;
        push_step(8'hFF);
        run(10);
        div = 16'd3;
        run(35);
        // async reset during data bit 5 with three bytes queued
        div = 16'd2;
        for (int i = 0; i < 4; i++) push_step(8'($urandom));
        run(9);
        async_reset();
        run(30);
        // push while full coincident with a pop, then non-full push with a pop
        div = 16'd1;
        stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_step(8'($urandom));
        stall = 1'b0;
        push_step(8'($urandom));
        run(9);
        push_step(8'($urandom));
        run(90);
        // random traffic with occasional stall and divisor changes
        for (int i = 0; i < 2000; i++) begin
            we = $urandom_range(0, 3) == 0;
            data = 8'($urandom);
            if ($urandom_range(0, 150) == 0) stall = ~stall;
            if ($urandom_range(0, 100) == 0) div = 16'($urandom_range(0, 4));
            step();
        end
        we = 1'b0;
        stall = 1'b0;
        div = 16'd2;
        run(200);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
